// File: rtl/colormap_pkg.sv
// Shared types and the heatmap helper for the gray-to-RGB colormap stream.
package colormap_pkg;

  typedef enum logic [1:0] {CM_GRAY, CM_HEAT, CM_IHEAT, CM_THRESH} cmap_mode_t;

  localparam int          SEG_W    = 64;
  localparam int          SEG_BITS = $clog2(SEG_W);
  localparam logic [7:0]  FULL     = 8'd255;

  typedef struct packed {
    logic       sof;
    cmap_mode_t mode;
    logic [7:0] thresh;
    logic [7:0] gray;
  } s1_t;

  typedef struct packed {
    logic        sof;
    logic [23:0] pixel;
  } s2_t;

  // Four 64-wide segments: blue -> cyan -> green -> yellow -> red.
  function automatic logic [23:0] heat_rgb(input logic [7:0] g);
    logic [7:0] f;
    logic [7:0] nf;
    f  = {g[SEG_BITS-1:0], 2'b00};
    nf = FULL - f;
    case (g[7:SEG_BITS])
      2'd0:    heat_rgb = {8'd0, f,    FULL};
      2'd1:    heat_rgb = {8'd0, FULL, nf};
      2'd2:    heat_rgb = {f,    FULL, 8'd0};
      default: heat_rgb = {FULL, nf,   8'd0};
    endcase
  endfunction

endpackage

// File: rtl/gray_colormap_stream_stage.sv
// One valid/ready register slice; an empty slot always accepts.
module pix_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/gray_colormap_stream.sv
// Two-stage gray -> RGB colormap stream; map and threshold latch on each accepted SOF beat.
module gray_colormap_stream
  import colormap_pkg::*;
#(
  parameter logic [7:0] THRESH_RST = 8'h80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_gray,
  input  logic        in_sof,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_thresh,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_pixel,
  output logic        out_sof
);

  cmap_mode_t mode_q, mode_d;
  logic [7:0] thresh_q, thresh_d;

  s1_t  s1_in, s1_out;
  s2_t  s2_in, s2_out;
  logic v1, rdy2, v2;
  logic accept;

  assign accept = in_valid && in_ready;

  // The SOF beat itself already uses the freshly sampled configuration.
  always_comb begin
    mode_d   = mode_q;
    thresh_d = thresh_q;
    if (accept && in_sof) begin
      mode_d   = cmap_mode_t'(cfg_mode);
      thresh_d = cfg_thresh;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= CM_GRAY;
      thresh_q <= THRESH_RST;
    end else begin
      mode_q   <= mode_d;
      thresh_q <= thresh_d;
    end
  end

  always_comb begin
    s1_in.sof    = in_sof;
    s1_in.mode   = in_sof ? cmap_mode_t'(cfg_mode) : mode_q;
    s1_in.thresh = in_sof ? cfg_thresh : thresh_q;
    s1_in.gray   = in_gray;
  end

  pix_pipe_stage #(.W($bits(s1_t))) u_stage1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (s1_in),
    .in_ready  (in_ready),
    .out_valid (v1),
    .out_ready (rdy2),
    .out_data  (s1_out)
  );

  always_comb begin
    s2_in.sof   = s1_out.sof;
    s2_in.pixel = {s1_out.gray, s1_out.gray, s1_out.gray};
    case (s1_out.mode)
      CM_HEAT:   s2_in.pixel = heat_rgb(s1_out.gray);
      CM_IHEAT:  s2_in.pixel = heat_rgb(FULL - s1_out.gray);
      CM_THRESH: s2_in.pixel = (s1_out.gray >= s1_out.thresh) ? 24'hFFFFFF : 24'h000000;
      default:   ;
    endcase
  end

  pix_pipe_stage #(.W($bits(s2_t))) u_stage2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v1),
    .in_data   (s2_in),
    .in_ready  (rdy2),
    .out_valid (v2),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign out_valid = v2;
  assign out_pixel = s2_out.pixel;
  assign out_sof   = s2_out.sof;

endmodule

// File: tb/tb_gray_colormap_stream.sv
// Scoreboard bench: accepted beats push a modelled pixel, emitted beats pop and compare.
module tb_gray_colormap_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_gray = 8'h00;
  logic        in_sof = 1'b0;
  logic [1:0]  cfg_mode = 2'b00;
  logic [7:0]  cfg_thresh = 8'h80;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_pixel;
  logic        out_sof;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_out = 0;
  bit chk_lat = 0;

  logic [24:0] exp_q[$];
  int          stamp_q[$];
  logic [1:0]  m_mode = 2'b00;
  logic [7:0]  m_th = 8'h80;
  bit          hold = 0;
  logic [24:0] hold_val;

  gray_colormap_stream #(.THRESH_RST(8'h80)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_gray    (in_gray),
    .in_sof     (in_sof),
    .cfg_mode   (cfg_mode),
    .cfg_thresh (cfg_thresh),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_sof    (out_sof)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] heat_m(input int g);
    int f;
    f = (g % 64) * 4;
    if (g < 64)       return {8'd0, 8'(f), 8'd255};
    else if (g < 128) return {8'd0, 8'd255, 8'(255 - f)};
    else if (g < 192) return {8'(f), 8'd255, 8'd0};
    else              return {8'd255, 8'(255 - f), 8'd0};
  endfunction

  function automatic logic [23:0] model(input logic [7:0] g, input logic [1:0] m, input logic [7:0] th);
    case (m)
      2'd0:    return {g, g, g};
      2'd1:    return heat_m(int'(g));
      2'd2:    return heat_m(255 - int'(g));
      default: return (g >= th) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      hold = 0;
    end else begin
      cyc++;
      if (hold) begin
        total++;
        if ({out_sof, out_pixel} !== hold_val) begin
          bad++;
          $display("FAIL stall_stable got=%h want=%h", {out_sof, out_pixel}, hold_val);
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out got=%h", {out_sof, out_pixel});
        end else begin
          logic [24:0] e;
          int          st;
          e  = exp_q.pop_front();
          st = stamp_q.pop_front();
          if ({out_sof, out_pixel} !== e) begin
            bad++;
            $display("FAIL out_pixel got=%h want=%h", {out_sof, out_pixel}, e);
          end
          if (chk_lat) begin
            total++;
            if (cyc - st != 2) begin
              bad++;
              $display("FAIL latency got=%0d want=2", cyc - st);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        if (in_sof) begin
          m_mode = cfg_mode;
          m_th   = cfg_thresh;
        end
        exp_q.push_back({in_sof, model(in_gray, m_mode, m_th)});
        stamp_q.push_back(cyc);
      end
      hold     = out_valid && !out_ready;
      hold_val = {out_sof, out_pixel};
    end
  end

  task automatic drive(input logic v, input logic [7:0] g, input logic s, input logic ordy, output logic acc);
    in_valid  = v;
    in_gray   = g;
    in_sof    = s;
    out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    stamp_q.delete();
    m_mode = 2'b00;
    m_th   = 8'h80;
    reset  = 1'b0;
    @(negedge clk);
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    if (out_pixel !== 24'h0) begin bad++; $display("FAIL rst_out_pixel got=%h want=000000", out_pixel); end
    if (out_sof !== 1'b0) begin bad++; $display("FAIL rst_out_sof got=%b want=0", out_sof); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_heat();
    logic [7:0] g_tab[5] = '{8'h00, 8'h20, 8'h40, 8'h80, 8'hFF};
    logic acc;
    chk_lat  = 1;
    cfg_mode = 2'b01;
    foreach (g_tab[i]) begin
      drive(1'b1, g_tab[i], 1'b1, 1'b1, acc);
      drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
      drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
    end
    drain();
    chk_lat = 0;
  endtask

  task automatic test_gray_iheat();
    logic acc;
    cfg_mode = 2'b00;
    drive(1'b1, 8'h5A, 1'b1, 1'b1, acc);
    cfg_mode = 2'b10;
    drive(1'b1, 8'h00, 1'b1, 1'b1, acc);
    drive(1'b1, 8'hFF, 1'b0, 1'b1, acc);
    drain();
  endtask

  task automatic test_thresh();
    logic acc;
    cfg_mode   = 2'b11;
    cfg_thresh = 8'h80;
    drive(1'b1, 8'h7F, 1'b1, 1'b1, acc);
    cfg_mode   = 2'b00;
    cfg_thresh = 8'h90;
    drive(1'b1, 8'h80, 1'b0, 1'b1, acc);
    drive(1'b1, 8'h81, 1'b0, 1'b1, acc);
    cfg_mode = 2'b11;
    drive(1'b1, 8'h85, 1'b1, 1'b1, acc);
    drive(1'b1, 8'h90, 1'b0, 1'b1, acc);
    drain();
  endtask

  task automatic test_backpressure();
    logic acc;
    int   n0, tries, n;
    n0 = n_out;
    cfg_mode = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      do begin
        drive(1'b1, 8'(i * 28), (i == 0), 1'($urandom_range(0, 1)), acc);
        tries++;
      end while (!acc && tries < 50);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      drive(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)), acc);
      n++;
    end
    total++;
    if (n_out - n0 != 10) begin
      bad++;
      $display("FAIL bp_count got=%0d want=10", n_out - n0);
    end
  endtask

  task automatic test_stall_fill();
    logic acc;
    int   na;
    na = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, acc);
      if (acc) na++;
    end
    total += 2;
    if (na != 2) begin bad++; $display("FAIL stall_accepts got=%0d want=2", na); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    na = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, acc);
      if (acc) na++;
    end
    total++;
    if (na != 6) begin bad++; $display("FAIL release_rate got=%0d want=6", na); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   na;
    na = 0;
    chk_lat  = 1;
    cfg_mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i * 33), (i == 0), 1'b1, acc);
      if (acc) na++;
    end
    total++;
    if (na != 8) begin bad++; $display("FAIL b2b_accepts got=%0d want=8", na); end
    drain();
    chk_lat = 0;
  endtask

  task automatic test_reset_midflight();
    logic acc;
    int   n0;
    cfg_mode = 2'b01;
    drive(1'b1, 8'h10, 1'b1, 1'b1, acc);
    drive(1'b1, 8'h20, 1'b0, 1'b1, acc);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    exp_q.delete();
    stamp_q.delete();
    m_mode = 2'b00;
    m_th   = 8'h80;
    reset  = 1'b0;
    n0 = n_out;
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
    total++;
    if (n_out != n0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", n_out - n0); end
    drive(1'b1, 8'h33, 1'b0, 1'b1, acc);
    drain();
  endtask

  initial begin
    test_reset();
    test_heat();
    test_gray_iheat();
    test_thresh();
    test_backpressure();
    test_stall_fill();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
